// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default line settings and the bit-period helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
    localparam int unsigned BAUD_DEFAULT   = 115_200;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
`ifdef UART_RX_PARITY_EN
        ,
        StParity
`endif
    } rx_state_e;

    // Also used by the TX side, so both ends agree on the bit period.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Byte-level output bundle of the UART receiver towards the command/response manager.
interface uart_rx_deframer_if;
    logic       recived_sig;
    logic [7:0] recived_data;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    modport master (
        output recived_sig,
        output recived_data,
        output frame_err,
        output parity_err,
        output rx_busy
    );

    modport slave (
        input recived_sig,
        input recived_data,
        input frame_err,
        input parity_err,
        input rx_busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous input; both flops reset to ResetVal.
module uart_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start/data/stop validation, one-cycle pulses for good bytes and errors.
// Define UART_RX_PARITY_EN to add an even-parity bit and a live parity_err.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int unsigned BAUD         = BAUD_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input logic                clk100mhz,
    input logic                cpu_reset,
    input logic                uart_txd_in,
    uart_rx_deframer_if.master rx
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    logic            rx_line;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            sig_q, sig_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d;
    logic            par_bad_q, par_bad_d;
`endif

    uart_sync2 #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk_i(clk100mhz),
        .rst_i(cpu_reset),
        .d_i  (uart_txd_in),
        .q_o  (rx_line)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        sig_d   = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_line) begin
                    state_d = StStart;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d = rx_line ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_line, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_line != (^shift_q));
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (!rx_line) begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) begin
                        perr_d  = 1'b1;
                        state_d = StIdle;
                    end
`endif
                    else begin
                        sig_d   = 1'b1;
                        data_d  = shift_q;
                        state_d = StIdle;
                    end
                end
            end
            StBreak: begin
                // Hold here so a line stuck low reports only one frame error.
                cnt_d = '0;
                if (rx_line) begin
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk100mhz or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            sig_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            sig_q   <= sig_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign rx.recived_sig  = sig_q;
    assign rx.recived_data = data_q;
    assign rx.frame_err    = ferr_q;
    assign rx.rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err   = perr_q;
`else
    assign rx.parity_err   = 1'b0;
`endif
endmodule
